// File: rtl/pipelined_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_magnitude_comparator
// Purpose  : Pipelined signed/unsigned magnitude comparator. Per-bit Gr/Eq
//            slices feed a pairwise merge tree with one register stage per
//            tree level. Operands enter and results leave through
//            valid/ready handshakes with full backpressure (global stall).
// Ports    : clk, rst_n              - clock, async active-low reset
//            in_valid/in_ready       - operand handshake
//            a, b [WIDTH]            - operands
//            is_signed               - 1: two's complement, 0: unsigned
//            in_tag [TAG_W]          - sideband returned with the result
//            out_valid/out_ready     - result handshake
//            gt, eq, lt              - one-hot compare flags
//            out_tag [TAG_W]         - tag belonging to the result
// Latency  : LVL+1 register stages, LVL = log2(WIDTH); 1 pair per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_magnitude_comparator #(
    parameter int WIDTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LVL  = $clog2(WIDTH);
    // All tree levels are packed into one flat vector: level k starts at
    // bit 2*WIDTH - 2*(WIDTH>>k) and holds WIDTH>>k Gr/Eq pairs.
    localparam int FLAT = 2 * WIDTH - 1;

    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_badWidth
            $error("pipelined_magnitude_comparator: WIDTH must be a power of two >= 2");
        end
    endgenerate

    logic                       w_advance;
    logic [WIDTH-1:0]           w_aMap;
    logic [WIDTH-1:0]           w_bMap;
    logic [FLAT-1:0]            r_gr;
    logic [FLAT-1:0]            r_eq;
    logic [FLAT-1:0]            w_grNext;
    logic [FLAT-1:0]            w_eqNext;
    logic [LVL:0]               r_vld;
    logic [LVL:0]               w_vldNext;
    logic [LVL:0][TAG_W-1:0]    r_tag;
    logic [LVL:0][TAG_W-1:0]    w_tagNext;
    logic                       r_lt;

    // Whole pipeline moves together whenever the output slot is free or
    // being emptied this cycle.
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    // Flipping both MSBs maps two's complement onto offset binary, so the
    // unsigned slice tree then yields the signed ordering.
    assign w_aMap = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
    assign w_bMap = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};

    assign w_grNext[WIDTH-1:0] = w_aMap & ~w_bMap;
    assign w_eqNext[WIDTH-1:0] = ~(w_aMap ^ w_bMap);

    genvar k, j;
    generate
        for (k = 1; k <= LVL; k++) begin : g_level
            localparam int SRC = 2 * WIDTH - 2 * (WIDTH >> (k - 1));
            localparam int DST = 2 * WIDTH - 2 * (WIDTH >> k);
            for (j = 0; j < (WIDTH >> k); j++) begin : g_pair
                // Upper (higher-index) slice decides unless it is equal.
                assign w_eqNext[DST+j] = r_eq[SRC+2*j+1] & r_eq[SRC+2*j];
                assign w_grNext[DST+j] = r_gr[SRC+2*j+1]
                                       | (r_eq[SRC+2*j+1] & r_gr[SRC+2*j]);
            end
        end
    endgenerate

    assign w_vldNext = {r_vld[LVL-1:0], in_valid & in_ready};
    assign w_tagNext = {r_tag[LVL-1:0], in_tag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_gr  <= '0;
            r_eq  <= '0;
            r_tag <= '0;
            r_lt  <= 1'b0;
        end else if (w_advance) begin
            r_vld <= w_vldNext;
            r_gr  <= w_grNext;
            r_eq  <= w_eqNext;
            r_tag <= w_tagNext;
            // lt is formed from the last merge so it is registered with gt/eq.
            r_lt  <= ~w_grNext[FLAT-1] & ~w_eqNext[FLAT-1];
        end
    end

    assign out_valid = r_vld[LVL];
    assign gt        = r_gr[FLAT-1];
    assign eq        = r_eq[FLAT-1];
    assign lt        = r_lt;
    assign out_tag   = r_tag[LVL];

endmodule
`default_nettype wire
